// File: rtl/pe_stream_driver.sv
// Drives one PE through a full sliding-window job: config, filter, ifmap, ipsum, opsum collection.
// Buffer reads have 1-cycle latency; a single holding slot keeps each send stream at 1 word/cycle.
module pe_stream_driver #(
    parameter int DATA_BITS   = 32,
    parameter int ADDR_BITS   = 16,
    parameter int CONFIG_SIZE = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cfg_mode,
    input  logic [1:0]             cfg_p,
    input  logic [4:0]             cfg_f,
    input  logic [1:0]             cfg_q,
    input  logic [7:0]             num_windows,
    input  logic [ADDR_BITS-1:0]   filt_base,
    input  logic [ADDR_BITS-1:0]   ifmap_base,
    input  logic [ADDR_BITS-1:0]   ipsum_base,
    input  logic [ADDR_BITS-1:0]   opsum_base,
    output logic                   mem_ren,
    output logic [ADDR_BITS-1:0]   mem_raddr,
    input  logic [DATA_BITS-1:0]   mem_rdata,
    output logic                   mem_wen,
    output logic [ADDR_BITS-1:0]   mem_waddr,
    output logic [DATA_BITS-1:0]   mem_wdata,
    output logic                   PE_en,
    output logic [CONFIG_SIZE-1:0] i_config,
    output logic [DATA_BITS-1:0]   filter,
    output logic [DATA_BITS-1:0]   ifmap,
    output logic [DATA_BITS-1:0]   ipsum,
    output logic                   filter_valid,
    output logic                   ifmap_valid,
    output logic                   ipsum_valid,
    input  logic                   filter_ready,
    input  logic                   ifmap_ready,
    input  logic                   ipsum_ready,
    input  logic [DATA_BITS-1:0]   opsum,
    input  logic                   opsum_valid,
    output logic                   opsum_ready,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        IDLE, CONFIG, SEND_FILT, SEND_IFMAP, SEND_IPSUM, RECV_OPSUM, DONE
    } state_t;

    state_t                 state;
    logic [CONFIG_SIZE-1:0] cfg_r;
    logic [1:0]             p_r;
    logic [7:0]             nw_r;
    logic [7:0]             win_r;
    logic [ADDR_BITS-1:0]   filt_base_r;
    logic [ADDR_BITS-1:0]   ifmap_base_r;
    logic [ADDR_BITS-1:0]   ipsum_base_r;
    logic [ADDR_BITS-1:0]   opsum_base_r;
    logic [3:0]             issued;
    logic [3:0]             xfer;
    logic [1:0]             ocnt;

    logic                   rd_vld_p1;
    logic                   hold_vld_p1;
    logic [DATA_BITS-1:0]   hold_data_p1;

    logic                   send_state;
    logic                   slot_full;
    logic                   out_vld;
    logic                   out_rdy;
    logic                   consume;
    logic                   last_xfer;
    logic [3:0]             pp1;
    logic [3:0]             filt_cnt;
    logic [3:0]             word_cnt;
    logic [ADDR_BITS-1:0]   rd_addr;
    logic [ADDR_BITS-1:0]   win_off;
    logic [DATA_BITS-1:0]   word;

    assign pp1      = {2'b00, p_r} + 4'd1;
    assign filt_cnt = (pp1 << 1) + pp1;
    assign win_off  = ADDR_BITS'({win_r, 2'b00});

    always_comb begin
        word_cnt = 4'd0;
        rd_addr  = '0;
        out_rdy  = 1'b0;
        case (state)
            SEND_FILT: begin
                word_cnt = filt_cnt;
                rd_addr  = filt_base_r + ADDR_BITS'(issued);
                out_rdy  = filter_ready;
            end
            SEND_IFMAP: begin
                if (win_r == 8'd0) begin
                    word_cnt = 4'd3;
                    rd_addr  = ifmap_base_r + ADDR_BITS'(issued);
                end else begin
                    // Later windows slide by one column: only the newest ifmap word is needed.
                    word_cnt = 4'd1;
                    rd_addr  = ifmap_base_r + ADDR_BITS'(win_r) + ADDR_BITS'(2);
                end
                out_rdy = ifmap_ready;
            end
            SEND_IPSUM: begin
                word_cnt = 4'd4;
                rd_addr  = ipsum_base_r + win_off + ADDR_BITS'(issued);
                out_rdy  = ipsum_ready;
            end
            default: ;
        endcase
    end

    // Stage p0: read issue; stage p1: returning word is bypassed to the PE or parked in the slot.
    assign send_state = (state == SEND_FILT) || (state == SEND_IFMAP) || (state == SEND_IPSUM);
    assign slot_full  = rd_vld_p1 | hold_vld_p1;
    assign out_vld    = send_state & slot_full;
    assign consume    = out_vld & out_rdy;
    assign last_xfer  = consume && (xfer == word_cnt - 4'd1);
    assign mem_ren    = send_state && (issued < word_cnt) && (!slot_full || consume);
    assign mem_raddr  = mem_ren ? rd_addr : '0;
    assign word       = rd_vld_p1 ? mem_rdata : hold_data_p1;

    assign filter_valid = out_vld && (state == SEND_FILT);
    assign ifmap_valid  = out_vld && (state == SEND_IFMAP);
    assign ipsum_valid  = out_vld && (state == SEND_IPSUM);
    assign filter       = filter_valid ? word : '0;
    assign ifmap        = ifmap_valid ? word : '0;
    assign ipsum        = ipsum_valid ? word : '0;

    assign opsum_ready = (state == RECV_OPSUM);
    assign mem_wen     = opsum_valid && opsum_ready;
    assign mem_waddr   = mem_wen ? (opsum_base_r + win_off + ADDR_BITS'(ocnt)) : '0;
    assign mem_wdata   = mem_wen ? opsum : '0;

    assign PE_en    = (state == CONFIG);
    assign i_config = PE_en ? cfg_r : '0;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cfg_r        <= '0;
            p_r          <= '0;
            nw_r         <= '0;
            win_r        <= '0;
            filt_base_r  <= '0;
            ifmap_base_r <= '0;
            ipsum_base_r <= '0;
            opsum_base_r <= '0;
            issued       <= '0;
            xfer         <= '0;
            ocnt         <= '0;
            rd_vld_p1    <= 1'b0;
            hold_vld_p1  <= 1'b0;
        end else begin
            rd_vld_p1   <= mem_ren;
            hold_vld_p1 <= slot_full && !consume;
            if (mem_ren) issued <= issued + 4'd1;
            if (consume) xfer <= xfer + 4'd1;
            if (last_xfer) begin
                issued <= '0;
                xfer   <= '0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_r        <= CONFIG_SIZE'({cfg_mode, cfg_p, cfg_f, cfg_q});
                        p_r          <= cfg_p;
                        nw_r         <= num_windows;
                        filt_base_r  <= filt_base;
                        ifmap_base_r <= ifmap_base;
                        ipsum_base_r <= ipsum_base;
                        opsum_base_r <= opsum_base;
                        win_r        <= '0;
                        ocnt         <= '0;
                        issued       <= '0;
                        xfer         <= '0;
                        state        <= (num_windows == 8'd0) ? DONE : CONFIG;
                    end
                end
                CONFIG:     state <= SEND_FILT;
                SEND_FILT:  if (last_xfer) state <= SEND_IFMAP;
                SEND_IFMAP: if (last_xfer) state <= SEND_IPSUM;
                SEND_IPSUM: if (last_xfer) state <= RECV_OPSUM;
                RECV_OPSUM: begin
                    if (mem_wen) begin
                        ocnt <= ocnt + 2'd1;
                        if (ocnt == 2'd3) begin
                            if (({1'b0, win_r} + 9'd1) < {1'b0, nw_r}) begin
                                win_r <= win_r + 8'd1;
                                state <= SEND_IFMAP;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE:       state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rd_vld_p1 && !consume) hold_data_p1 <= mem_rdata;
    end

endmodule

// File: tb/tb_pe_stream_driver.sv
// Bench for pe_stream_driver: buffer and PE models around the DUT, scoreboard queues of expected traffic.
module tb_pe_stream_driver;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int CW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, cfg_mode;
    logic [1:0]    cfg_p, cfg_q;
    logic [4:0]    cfg_f;
    logic [7:0]    num_windows;
    logic [AW-1:0] filt_base, ifmap_base, ipsum_base, opsum_base;
    logic          mem_ren, mem_wen;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [DW-1:0] mem_rdata, mem_wdata;
    logic          PE_en;
    logic [CW-1:0] i_config;
    logic [DW-1:0] filter, ifmap, ipsum, opsum;
    logic          filter_valid, ifmap_valid, ipsum_valid;
    logic          filter_ready, ifmap_ready, ipsum_ready;
    logic          opsum_valid, opsum_ready, busy, done;

    pe_stream_driver #(.DATA_BITS(DW), .ADDR_BITS(AW), .CONFIG_SIZE(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_p(cfg_p),
        .cfg_f(cfg_f), .cfg_q(cfg_q), .num_windows(num_windows),
        .filt_base(filt_base), .ifmap_base(ifmap_base), .ipsum_base(ipsum_base),
        .opsum_base(opsum_base), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .PE_en(PE_en), .i_config(i_config),
        .filter(filter), .ifmap(ifmap), .ipsum(ipsum),
        .filter_valid(filter_valid), .ifmap_valid(ifmap_valid), .ipsum_valid(ipsum_valid),
        .filter_ready(filter_ready), .ifmap_ready(ifmap_ready), .ipsum_ready(ipsum_ready),
        .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready),
        .busy(busy), .done(done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return {a ^ 16'h8C3A, a};
    endfunction

    logic [AW-1:0] q_raddr[$];
    logic [AW-1:0] q_waddr[$];
    logic [DW-1:0] q_f[$];
    logic [DW-1:0] q_i[$];
    logic [DW-1:0] q_s[$];
    logic [DW-1:0] q_wd[$];
    logic [CW-1:0] exp_cfg;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer read port and PE model, driven just after each rising edge.
    int            rmode = 0;
    int            pcnt  = 0;
    logic          rd_pend = 1'b0;
    logic [AW-1:0] rd_a = '0;
    logic [3:0]    pat = 4'b1001;
    initial begin
        filter_ready = 1'b0; ifmap_ready = 1'b0; ipsum_ready = 1'b0;
        opsum_valid = 1'b0; opsum = '0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_rdata = rd_pend ? memval(rd_a) : DW'($urandom);
            pcnt++;
            case (rmode)
                0: begin filter_ready = 1'b1; ifmap_ready = 1'b1; ipsum_ready = 1'b1; end
                1: begin filter_ready = pat[pcnt % 4]; ifmap_ready = 1'b1; ipsum_ready = 1'b1; end
                default: begin
                    filter_ready = 1'($urandom_range(0, 1));
                    ifmap_ready  = 1'($urandom_range(0, 1));
                    ipsum_ready  = 1'($urandom_range(0, 1));
                end
            endcase
            opsum = DW'($urandom);
            if (opsum_ready) begin
                opsum_valid = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (opsum_valid) q_wd.push_back(opsum);
            end else begin
                opsum_valid = 1'b0;
            end
        end
    end

    int            pe_cnt, done_cnt, done_cyc, ren_cnt, wcnt, w_first, w_last;
    int            nxf[3], first_c[3], last_c[3];
    bit            stall_prev[3];
    logic [DW-1:0] dprev[3];
    logic [2:0]    sv, sr;
    logic [DW-1:0] sd[3];
    string         nm[3] = '{"filter", "ifmap", "ipsum"};

    always @(negedge clk) begin
        sv = {ipsum_valid, ifmap_valid, filter_valid};
        sr = {ipsum_ready, ifmap_ready, filter_ready};
        sd[0] = filter; sd[1] = ifmap; sd[2] = ipsum;
        rd_pend = mem_ren;
        rd_a    = mem_raddr;
        if (mem_ren) begin
            ren_cnt++;
            if (q_raddr.size() == 0) check("ren_extra", 1, 0);
            else check("raddr", mem_raddr, q_raddr.pop_front());
        end
        if (|sv) check("one_valid", (sv & (sv - 3'd1)) == 3'd0, 1);
        for (int i = 0; i < 3; i++) begin
            if (stall_prev[i] && busy) begin
                check({nm[i], "_hold_valid"}, sv[i], 1);
                check({nm[i], "_hold_data"}, sd[i], dprev[i]);
            end
            if (sv[i] && sr[i]) begin
                nxf[i]++;
                if (nxf[i] == 1) first_c[i] = cyc;
                last_c[i] = cyc;
                if (i == 0) begin
                    if (q_f.size() == 0) check("filter_extra", 1, 0);
                    else check("filter_data", sd[0], q_f.pop_front());
                end else if (i == 1) begin
                    if (q_i.size() == 0) check("ifmap_extra", 1, 0);
                    else check("ifmap_data", sd[1], q_i.pop_front());
                end else begin
                    if (q_s.size() == 0) check("ipsum_extra", 1, 0);
                    else check("ipsum_data", sd[2], q_s.pop_front());
                end
            end
            stall_prev[i] = sv[i] && !sr[i];
            dprev[i] = sd[i];
        end
        if (mem_wen || (opsum_valid && opsum_ready)) begin
            check("wen", mem_wen, opsum_valid && opsum_ready);
            wcnt++;
            if (wcnt == 1) w_first = cyc;
            w_last = cyc;
            if (q_waddr.size() == 0 || q_wd.size() == 0) check("write_extra", 1, 0);
            else begin
                check("waddr", mem_waddr, q_waddr.pop_front());
                check("wdata", mem_wdata, q_wd.pop_front());
            end
        end
        if (PE_en) begin
            pe_cnt++;
            check("i_config", i_config, exp_cfg);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", busy, 1);
        end
    end

    task automatic clear_counts();
        pe_cnt = 0; done_cnt = 0; ren_cnt = 0; wcnt = 0;
        for (int i = 0; i < 3; i++) nxf[i] = 0;
    endtask

    task automatic load_exp(input int p, input int nw, input logic [AW-1:0] fb, ib, sb, ob);
        logic [AW-1:0] a;
        if (nw == 0) return;
        for (int k = 0; k < 3 * (p + 1); k++) begin
            a = fb + AW'(k); q_raddr.push_back(a); q_f.push_back(memval(a));
        end
        for (int w = 0; w < nw; w++) begin
            if (w == 0) begin
                for (int k = 0; k < 3; k++) begin
                    a = ib + AW'(k); q_raddr.push_back(a); q_i.push_back(memval(a));
                end
            end else begin
                a = ib + AW'(w + 2); q_raddr.push_back(a); q_i.push_back(memval(a));
            end
            for (int j = 0; j < 4; j++) begin
                a = sb + AW'(4 * w + j); q_raddr.push_back(a); q_s.push_back(memval(a));
                q_waddr.push_back(ob + AW'(4 * w + j));
            end
        end
    endtask

    int st_cyc;
    task automatic kick(input int p, input int q, input int nw, input logic [AW-1:0] fb, ib, sb, ob);
        logic       mo = 1'($urandom);
        logic [4:0] f  = 5'($urandom);
        exp_cfg = {mo, 2'(p), f, 2'(q)};
        @(posedge clk); #1;
        start = 1'b1; cfg_mode = mo; cfg_p = 2'(p); cfg_f = f; cfg_q = 2'(q);
        num_windows = 8'(nw);
        filt_base = fb; ifmap_base = ib; ipsum_base = sb; opsum_base = ob;
        st_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; cfg_mode = 1'($urandom); cfg_p = 2'($urandom); cfg_f = 5'($urandom);
        cfg_q = 2'($urandom); num_windows = 8'($urandom);
        filt_base = AW'($urandom); ifmap_base = AW'($urandom);
        ipsum_base = AW'($urandom); opsum_base = AW'($urandom);
    endtask

    task automatic run_job(input int p, input int q, input int nw, input logic [AW-1:0] fb, ib, sb, ob,
                           input int rm, input bit dup);
        int nf, ni, t;
        nf = (nw > 0) ? 3 * (p + 1) : 0;
        ni = (nw > 0) ? nw + 2 : 0;
        clear_counts();
        rmode = rm;
        load_exp(p, nw, fb, ib, sb, ob);
        kick(p, q, nw, fb, ib, sb, ob);
        if (dup) begin
            repeat (6) @(posedge clk);
            #1 start = 1'b1; num_windows = 8'd7;
            @(posedge clk); #1 start = 1'b0;
        end
        t = 0;
        do begin @(negedge clk); t++; end while (!done && t < 3000);
        if (!done) check("timeout", 0, 1);
        else if (dup) begin
            start = 1'b1; num_windows = 8'd2;
            @(posedge clk); #1 start = 1'b0;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pe_en_count", pe_cnt, (nw > 0) ? 1 : 0);
        check("done_count", done_cnt, 1);
        check("filter_count", nxf[0], nf);
        check("ifmap_count", nxf[1], ni);
        check("ipsum_count", nxf[2], 4 * nw);
        check("write_count", wcnt, 4 * nw);
        check("ren_count", ren_cnt, nf + ni + 4 * nw);
        check("reads_left", q_raddr.size(), 0);
        check("writes_left", q_waddr.size(), 0);
        check("busy_after", busy, 0);
        if (rm == 0 && nw == 1) begin
            check("filter_b2b", last_c[0] - first_c[0], nf - 1);
            check("ifmap_b2b", last_c[1] - first_c[1], 2);
            check("ipsum_b2b", last_c[2] - first_c[2], 3);
            check("opsum_b2b", w_last - w_first, 3);
        end
        if (nw == 0) check("done_latency", (done_cyc - st_cyc >= 1) && (done_cyc - st_cyc <= 2), 1);
    endtask

    initial begin
        int t, ren_snap;
        rst = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_p = '0; cfg_f = '0; cfg_q = '0;
        num_windows = '0; filt_base = '0; ifmap_base = '0; ipsum_base = '0; opsum_base = '0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pe_en", PE_en, 0);
        check("rst_valids", {filter_valid, ifmap_valid, ipsum_valid}, 0);
        check("rst_mem", {mem_ren, mem_wen, opsum_ready}, 0);
        check("rst_cfg", i_config, 0);

        run_job(1, 0, 1, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 1'b0);
        run_job(1, 2, 1, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 1, 1'b0);
        run_job(3, 1, 3, 16'h0500, 16'h0600, 16'h0700, 16'hFFFE, 0, 1'b0);
        run_job(0, 3, 4, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00, 2, 1'b0);
        run_job(2, 0, 0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 1'b0);

        // Abort in the middle of the ipsum burst, then a clean rerun.
        clear_counts();
        rmode = 0;
        load_exp(1, 2, 16'h0110, 16'h0220, 16'h0330, 16'h0440);
        kick(1, 1, 2, 16'h0110, 16'h0220, 16'h0330, 16'h0440);
        t = 0;
        do begin @(negedge clk); t++; end while (!ipsum_valid && t < 500);
        check("abort_reached_ipsum", ipsum_valid, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        q_raddr.delete(); q_waddr.delete(); q_f.delete(); q_i.delete(); q_s.delete(); q_wd.delete();
        @(negedge clk);
        check("abort_valids", {filter_valid, ifmap_valid, ipsum_valid}, 0);
        check("abort_ren", mem_ren, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        ren_snap = ren_cnt;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("abort_quiet_ren", ren_cnt, ren_snap);
        check("abort_no_done", done_cnt, 0);
        run_job(1, 1, 2, 16'h0110, 16'h0220, 16'h0330, 16'h0440, 0, 1'b0);

        run_job(1, 0, 3, 16'h0040, 16'hFFFF, 16'h0080, 16'h00C0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
